pcm_multi: RTL and testbench

- Parametrised successor to the stereo PCM playback block.
- Accepts interleaved 8/16-bit PCM bytes from the CPU through a byte FIFO of configurable depth.
- On each sample-rate tick, fetches one complete frame of 1..NUM_CH channels and applies 16-step log volume.
- Drives NUM_CH 16-bit signed outputs to the audio mixer.
- New behaviour: atomic frame fetch, a sticky underrun flag, selectable hold/zero on underrun, rate clamping and a FIFO fill-level output.

---
 rtl/pcm_pkg.sv | 55 +++++
 rtl/pcm_multi_if.sv | 21 ++
 rtl/pcm_fifo.sv | 72 +++++++
 rtl/pcm_multi.sv | 168 ++++++++++++++++
 tb/tb_pcm_multi.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcm_pkg.sv
// pcm_multi shared package: fsm states, volume table,
// volume scaling and the channel/rate clamp helpers.
package pcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } pcm_state_e;

  localparam logic [6:0] VOL_LOG [16] = '{
    7'd0,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  7'd8,
    7'd11, 7'd14, 7'd18, 7'd23, 7'd30, 7'd38, 7'd49, 7'd64
  };

  // 22-bit signed product, keep [21:6]; gain 64 is unity.
  function automatic logic [15:0] vol_scale(
    logic [15:0] s,
    logic [3:0]  v
  );
    logic signed [21:0] se;
    logic signed [21:0] g;
    logic signed [21:0] p;
    se = {{6{s[15]}}, s};
    g  = {15'd0, VOL_LOG[v]};
    p  = se * g;
    return p[21:6];
  endfunction

  function automatic logic [3:0] clamp_ch(
    logic [3:0] c,
    int         n
  );
    if (c == 4'd0) return 4'd1;
    if (int'(c) > n) return 4'(n);
    return c;
  endfunction

  function automatic logic [4:0] frame_bytes(
    logic [3:0] c,
    logic       m16
  );
    return m16 ? {c, 1'b0} : {1'b0, c};
  endfunction

  function automatic logic [31:0] clamp_rate(
    logic [31:0] r,
    int          w
  );
    logic [31:0] lim;
    lim = 32'd1 << (w - 1);
    return (r > lim) ? lim : r;
  endfunction

endpackage

// File: rtl/pcm_multi_if.sv
// CPU-side FIFO write bus of pcm_multi.
// master = CPU, slave = pcm_multi.
interface pcm_multi_if #(
  parameter int LW = 13
) ();
  logic [7:0]    fifo_wrdata;
  logic          fifo_write;
  logic          fifo_full;
  logic          fifo_almost_empty;
  logic [LW-1:0] fifo_level;

  modport master (
    output fifo_wrdata, fifo_write,
    input  fifo_full, fifo_almost_empty, fifo_level
  );

  modport slave (
    input  fifo_wrdata, fifo_write,
    output fifo_full, fifo_almost_empty, fifo_level
  );
endinterface

// File: rtl/pcm_fifo.sv
// Synchronous byte FIFO with registered read data.
// Ports: flush, wr_en/wr_data, rd_en/rd_data, level, full, almost_empty.
module pcm_fifo #(
  parameter  int DEPTH     = 4096,
  parameter  int AE_THRESH = 1024,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          almost_empty
);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_rd     = rd_en && (level_q != '0) && !flush;
    // a pop in the same cycle frees the slot a full write needs
    do_wr     = wr_en && !flush &&
                ((level_q != LW'(DEPTH)) || do_rd);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      level_d = level_q + LW'(do_wr) - LW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign level        = level_q;
  assign full         = (level_q == LW'(DEPTH));
  assign almost_empty = (level_q < LW'(AE_THRESH));
endmodule

// File: rtl/pcm_multi.sv
// Multi-channel PCM playback: byte FIFO, rate accumulator, frame fetch, volume.
// Ports: clk/rst_n, rate/format/volume controls, cpu FIFO bus, underrun, audio_out.
module pcm_multi
  import pcm_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4096,
  parameter int RATE_W     = 8,
  parameter int AE_THRESH  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 next_sample,
  input  logic [RATE_W-1:0]    sample_rate,
  input  logic [3:0]           ch_count,
  input  logic                 mode_16bit,
  input  logic [3:0]           volume,
  input  logic                 underrun_hold,
  input  logic                 underrun_clr,
  input  logic                 fifo_reset,
  pcm_multi_if.slave           cpu,
  output logic                 underrun,
  output logic [NUM_CH*16-1:0] audio_out
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [RATE_W-1:0] rate, acc_q, acc_d;
  logic              trig_q, trig_d;
  pcm_state_e        st_q, st_d;
  logic [3:0]        c_q, c_d, c_now;
  logic              m16_q, m16_d;
  logic [4:0]        k_q, k_d, b_now, b_cur;
  logic [15:0]       cap_q [NUM_CH];
  logic [15:0]       cap_d [NUM_CH];
  logic [15:0]       out_q [NUM_CH];
  logic [15:0]       out_d [NUM_CH];
  logic [15:0]       aud_q [NUM_CH];
  logic [15:0]       aud_d [NUM_CH];
  logic              unr_q, unr_d;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic [LW-1:0]     level;

  pcm_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .AE_THRESH (AE_THRESH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (fifo_reset),
    .wr_en        (cpu.fifo_write),
    .wr_data      (cpu.fifo_wrdata),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .level        (level),
    .full         (cpu.fifo_full),
    .almost_empty (cpu.fifo_almost_empty)
  );

  assign cpu.fifo_level = level;
  assign rate  = RATE_W'(clamp_rate(32'(sample_rate), RATE_W));
  assign c_now = clamp_ch(ch_count, NUM_CH);
  assign b_now = frame_bytes(c_now, mode_16bit);
  assign b_cur = frame_bytes(c_q, m16_q);

  always_comb begin
    acc_d  = acc_q;
    trig_d = 1'b0;
    if (next_sample) begin
      acc_d  = acc_q + rate;
      trig_d = acc_d[RATE_W-1] ^ acc_q[RATE_W-1];
    end
  end

  always_comb begin
    st_d  = st_q;
    c_d   = c_q;
    m16_d = m16_q;
    k_d   = k_q;
    cap_d = cap_q;
    out_d = out_q;
    rd_en = 1'b0;
    unr_d = unr_q & ~underrun_clr;
    if (fifo_reset) begin
      st_d = ST_IDLE;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (trig_q) begin
            if (int'(level) >= int'(b_now)) begin
              rd_en = 1'b1;
              c_d   = c_now;
              m16_d = mode_16bit;
              k_d   = '0;
              st_d  = ST_FETCH;
            end else begin
              unr_d = 1'b1;
              if (!underrun_hold) begin
                for (int i = 0; i < NUM_CH; i++)
                  out_d[i] = '0;
              end
            end
          end
        end
        ST_FETCH: begin
          for (int j = 0; j < NUM_CH; j++) begin
            if (m16_q && int'(k_q[4:1]) == j) begin
              if (k_q[0]) cap_d[j][15:8] = rd_data;
              else        cap_d[j][7:0]  = rd_data;
            end else if (!m16_q && int'(k_q) == j) begin
              cap_d[j] = {rd_data, 8'h00};
            end
          end
          if (k_q == b_cur - 5'd1) begin
            st_d = ST_DONE;
          end else begin
            rd_en = 1'b1;
            k_d   = k_q + 5'd1;
          end
        end
        ST_DONE: begin
          // inactive channels replicate the active ones
          for (int i = 0; i < NUM_CH; i++)
            for (int j = 0; j < NUM_CH; j++)
              if (j == i % int'(c_q)) out_d[i] = cap_q[j];
          st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end
    for (int i = 0; i < NUM_CH; i++)
      aud_d[i] = vol_scale(out_q[i], volume);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      trig_q <= 1'b0;
      st_q   <= ST_IDLE;
      c_q    <= 4'd1;
      m16_q  <= 1'b0;
      k_q    <= '0;
      unr_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cap_q[i] <= '0;
        out_q[i] <= '0;
        aud_q[i] <= '0;
      end
    end else begin
      acc_q  <= acc_d;
      trig_q <= trig_d;
      st_q   <= st_d;
      c_q    <= c_d;
      m16_q  <= m16_d;
      k_q    <= k_d;
      unr_q  <= unr_d;
      cap_q  <= cap_d;
      out_q  <= out_d;
      aud_q  <= aud_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_out
    assign audio_out[16*i +: 16] = aud_q[i];
  end

  assign underrun = unr_q;
endmodule

// File: tb/tb_pcm_multi.sv
// Self-checking bench for pcm_multi: directed vector table,
// hand-written corner sequences and a randomized model check.
module tb_pcm_multi;
  localparam int NCH   = 4;
  localparam int DEPTH = 64;
  localparam int RW    = 8;
  localparam int AE    = 16;
  localparam int LW    = 7;
  localparam int VOLT [16] = '{0, 1, 2, 3, 4, 5, 6, 8,
                               11, 14, 18, 23, 30, 38, 49, 64};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              next_sample = 1'b0;
  logic [RW-1:0]     sample_rate = 8'd128;
  logic [3:0]        ch_count = 4'd2;
  logic              mode_16bit = 1'b1;
  logic [3:0]        volume = 4'd15;
  logic              underrun_hold = 1'b0;
  logic              underrun_clr = 1'b0;
  logic              fifo_reset = 1'b0;
  logic              underrun;
  logic [NCH*16-1:0] audio_out;

  pcm_multi_if #(.LW(LW)) cpu ();

  pcm_multi #(
    .NUM_CH     (NCH),
    .FIFO_DEPTH (DEPTH),
    .RATE_W     (RW),
    .AE_THRESH  (AE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .next_sample   (next_sample),
    .sample_rate   (sample_rate),
    .ch_count      (ch_count),
    .mode_16bit    (mode_16bit),
    .volume        (volume),
    .underrun_hold (underrun_hold),
    .underrun_clr  (underrun_clr),
    .fifo_reset    (fifo_reset),
    .cpu           (cpu),
    .underrun      (underrun),
    .audio_out     (audio_out)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  q[$];
  logic [15:0] m_out [NCH];
  logic        m_unr;

  typedef struct {
    logic [3:0]  cc;
    logic        m16;
    logic [3:0]  vol;
    logic        hold;
    int          n;
    logic [7:0]  b [8];
    logic [63:0] exp_audio;
    int          exp_lvl;
    logic        exp_unr;
  } vec_t;

  vec_t tbl [12];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [7:0] b);
    cpu.fifo_wrdata = b;
    cpu.fifo_write  = 1'b1;
    @(negedge clk);
    cpu.fifo_write  = 1'b0;
  endtask

  task automatic tick();
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
  endtask

  task automatic flush_clr();
    fifo_reset   = 1'b1;
    underrun_clr = 1'b1;
    @(negedge clk);
    fifo_reset   = 1'b0;
    underrun_clr = 1'b0;
  endtask

  function automatic logic [15:0] vscale(logic [15:0] s, logic [3:0] v);
    int p;
    p = int'($signed(s)) * VOLT[v];
    p = p >>> 6;
    return p[15:0];
  endfunction

  function automatic logic [63:0] exp_audio(logic [3:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[16*i +: 16] = vscale(m_out[i], v);
    return r;
  endfunction

  task automatic rand_iter(int it);
    int          c, b, n;
    logic [7:0]  fb[$];
    logic [15:0] smp [8];
    logic [7:0]  x;
    if ($urandom_range(0, 3) == 0) begin
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      m_unr = 1'b0;
    end
    if (q.size() > 40) begin
      fifo_reset = 1'b1;
      @(negedge clk);
      fifo_reset = 1'b0;
      q.delete();
    end
    ch_count      = 4'($urandom_range(0, 15));
    mode_16bit    = 1'($urandom);
    volume        = 4'($urandom);
    underrun_hold = 1'($urandom);
    n = $urandom_range(0, 10);
    for (int j = 0; j < n; j++) begin
      x = 8'($urandom);
      wr(x);
      q.push_back(x);
    end
    c = (ch_count == 0) ? 1 : (int'(ch_count) > NCH ? NCH : int'(ch_count));
    b = mode_16bit ? 2 * c : c;
    if (q.size() >= b) begin
      for (int j = 0; j < b; j++) fb.push_back(q.pop_front());
      for (int j = 0; j < c; j++)
        smp[j] = mode_16bit ? {fb[2*j+1], fb[2*j]} : {fb[j], 8'h00};
      for (int i = 0; i < NCH; i++) m_out[i] = smp[i % c];
    end else begin
      m_unr = 1'b1;
      if (!underrun_hold)
        for (int i = 0; i < NCH; i++) m_out[i] = '0;
    end
    tick();
    cyc(b + 6);
    check($sformatf("rand%0d audio", it), audio_out, exp_audio(volume));
    check($sformatf("rand%0d level", it), 64'(cpu.fifo_level), 64'(q.size()));
    check($sformatf("rand%0d underrun", it), 64'(underrun), 64'(m_unr));
  endtask

  initial begin
    cpu.fifo_write  = 1'b0;
    cpu.fifo_wrdata = 8'h00;

    tbl[0]  = '{4'd2, 1'b1, 4'd15, 1'b0, 4,
                '{8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h5678_1234_5678_1234, 0, 1'b0};
    tbl[1]  = '{4'd1, 1'b0, 4'd15, 1'b0, 1,
                '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h8000_8000_8000_8000, 0, 1'b0};
    tbl[2]  = '{4'd1, 1'b0, 4'd8, 1'b0, 1,
                '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'hEA00_EA00_EA00_EA00, 0, 1'b0};
    tbl[3]  = '{4'd2, 1'b1, 4'd15, 1'b1, 3,
                '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h8000_8000_8000_8000, 3, 1'b1};
    tbl[4]  = '{4'd2, 1'b1, 4'd15, 1'b0, 3,
                '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h0, 3, 1'b1};
    tbl[5]  = '{4'd4, 1'b1, 4'd15, 1'b0, 8,
                '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h34, 8'h12, 8'hCD, 8'hAB},
                64'hABCD_1234_8000_7FFF, 0, 1'b0};
    tbl[6]  = '{4'd0, 1'b0, 4'd15, 1'b0, 1,
                '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h4000_4000_4000_4000, 0, 1'b0};
    tbl[7]  = '{4'd9, 1'b0, 4'd15, 1'b0, 4,
                '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h0400_0300_0200_0100, 0, 1'b0};
    tbl[8]  = '{4'd3, 1'b0, 4'd15, 1'b0, 3,
                '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h1000_3000_2000_1000, 0, 1'b0};
    tbl[9]  = '{4'd1, 1'b0, 4'd4, 1'b0, 1,
                '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h0400_0400_0400_0400, 0, 1'b0};
    tbl[10] = '{4'd2, 1'b1, 4'd0, 1'b0, 4,
                '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h0, 0, 1'b0};
    tbl[11] = '{4'd2, 1'b0, 4'd15, 1'b0, 3,
                '{8'hC0, 8'h7F, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                64'h7F00_C000_7F00_C000, 1, 1'b0};

    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("reset audio", audio_out, 64'h0);
    check("reset level", 64'(cpu.fifo_level), 64'h0);
    check("reset full", 64'(cpu.fifo_full), 64'h0);
    check("reset almost_empty", 64'(cpu.fifo_almost_empty), 64'h1);
    check("reset underrun", 64'(underrun), 64'h0);

    foreach (tbl[i]) begin
      flush_clr();
      ch_count      = tbl[i].cc;
      mode_16bit    = tbl[i].m16;
      volume        = tbl[i].vol;
      underrun_hold = tbl[i].hold;
      sample_rate   = 8'd128;
      for (int j = 0; j < tbl[i].n; j++) wr(tbl[i].b[j]);
      tick();
      cyc(16);
      check($sformatf("vec%0d audio", i), audio_out, tbl[i].exp_audio);
      check($sformatf("vec%0d level", i), 64'(cpu.fifo_level), 64'(tbl[i].exp_lvl));
      check($sformatf("vec%0d underrun", i), 64'(underrun), 64'(tbl[i].exp_unr));
    end

    // frame latency: new frame visible after E7 for B=4
    flush_clr();
    ch_count = 4'd2; mode_16bit = 1'b1; volume = 4'd15;
    wr(8'h34); wr(8'h12); wr(8'h78); wr(8'h56);
    tick();
    cyc(6);
    check("latency before E7", audio_out, 64'h7F00_C000_7F00_C000);
    cyc(1);
    check("latency after E7", audio_out, 64'h5678_1234_5678_1234);
    check("latency level", 64'(cpu.fifo_level), 64'h0);

    // underrun set wins over same-cycle clear
    flush_clr();
    next_sample = 1'b1;
    @(negedge clk);
    next_sample  = 1'b0;
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun set priority", 64'(underrun), 64'h1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun clear", 64'(underrun), 64'h0);
    cyc(10);
    check("idle empty no underrun", 64'(underrun), 64'h0);

    // rate divide
    flush_clr();
    ch_count = 4'd1; mode_16bit = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'h10);
    sample_rate = 8'd32;
    repeat (16) begin tick(); cyc(7); end
    check("rate32 level", 64'(cpu.fifo_level), 64'd12);
    check("rate32 underrun", 64'(underrun), 64'h0);
    flush_clr();
    for (int i = 0; i < 16; i++) wr(8'h10);
    sample_rate = 8'd255;
    repeat (16) begin tick(); cyc(7); end
    check("rate255 level", 64'(cpu.fifo_level), 64'd0);
    check("rate255 underrun", 64'(underrun), 64'h0);
    flush_clr();
    for (int i = 0; i < 5; i++) wr(8'h10);
    sample_rate = 8'd0;
    repeat (16) begin tick(); cyc(7); end
    check("rate0 level", 64'(cpu.fifo_level), 64'd5);
    check("rate0 almost_empty", 64'(cpu.fifo_almost_empty), 64'h1);
    sample_rate = 8'd128;

    // fifo_reset at k=3 of a 4-ch 16-bit fetch
    flush_clr();
    ch_count = 4'd4; mode_16bit = 1'b1;
    for (int i = 1; i <= 8; i++) wr(8'(i * 17));
    tick();
    cyc(16);
    check("4ch frame", audio_out, 64'h8877_6655_4433_2211);
    for (int i = 0; i < 8; i++) wr(8'hAA);
    tick();
    cyc(4);
    fifo_reset = 1'b1;
    @(negedge clk);
    fifo_reset = 1'b0;
    cyc(12);
    check("abort level", 64'(cpu.fifo_level), 64'h0);
    check("abort audio held", audio_out, 64'h8877_6655_4433_2211);
    for (int i = 1; i <= 8; i++) wr(8'(i));
    tick();
    cyc(16);
    check("after abort frame", audio_out, 64'h0807_0605_0403_0201);

    // full boundary
    flush_clr();
    ch_count = 4'd1; mode_16bit = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) wr(8'(8'h5A + i));
    check("full flag", 64'(cpu.fifo_full), 64'h1);
    check("full level", 64'(cpu.fifo_level), 64'(DEPTH));
    check("full almost_empty", 64'(cpu.fifo_almost_empty), 64'h0);
    tick();
    cpu.fifo_wrdata = 8'hEE;
    cpu.fifo_write  = 1'b1;
    @(negedge clk);
    cpu.fifo_write  = 1'b0;
    cyc(8);
    check("full rw level", 64'(cpu.fifo_level), 64'(DEPTH));
    check("full rw audio", audio_out, 64'h5A00_5A00_5A00_5A00);

    // randomized against the model
    flush_clr();
    q.delete();
    ch_count = 4'd2; mode_16bit = 1'b1; underrun_hold = 1'b0;
    tick();
    cyc(16);
    for (int i = 0; i < NCH; i++) m_out[i] = '0;
    m_unr = 1'b1;
    for (int it = 0; it < 40; it++) rand_iter(it);

    // asynchronous reset in the middle of a fetch
    flush_clr();
    ch_count = 4'd4; mode_16bit = 1'b1; volume = 4'd15;
    for (int i = 1; i <= 8; i++) wr(8'(i * 17));
    tick();
    cyc(16);
    for (int i = 1; i <= 8; i++) wr(8'(i));
    tick();
    cyc(3);
    rst_n = 1'b0;
    #1;
    check("async rst audio", audio_out, 64'h0);
    check("async rst level", 64'(cpu.fifo_level), 64'h0);
    check("async rst underrun", 64'(underrun), 64'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
